// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the dual-clock FIFO: hides the RAM's one-cycle read latency behind a
// 2-entry valid/ready buffer. Define RD_STREAM_STATS_EN to add the word_cnt/stall_cnt statistics.
module fifo_rd_stream #(
  parameter int DATA_WD = 8
) (
  input  logic               r_clk,
  input  logic               r_resetn,
  input  logic               empty_flag,
  input  logic [DATA_WD-1:0] data_out,
  output logic               r_enbl,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_WD-1:0] m_data
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [15:0]        word_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  logic [1:0]         count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [DATA_WD-1:0] head_q, head_d;
  logic [DATA_WD-1:0] skid_q, skid_d;
  logic               pop_s;
  logic [2:0]         level_s;
  logic [1:0]         kept_s;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q;

  // Read issue: only when the words held plus the one in flight, after this pop, leave room.
  always_comb begin
    pop_s   = m_valid & m_ready;
    level_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    kept_s  = count_q - {1'b0, pop_s};
    r_enbl  = r_resetn & ~empty_flag & ~flush & (level_s < 3'd2);
  end

  // Buffer next state: shift skid to head on pop, then land the arriving word in the first free slot.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    inflight_d = r_enbl;
    if (pop_s && (count_q == 2'd2)) begin
      head_d = skid_q;
    end else begin
      head_d = head_q;
    end
    if (inflight_q && !flush) begin
      if (kept_s == 2'd0) begin
        head_d = data_out;
      end else begin
        skid_d = data_out;
      end
    end else begin
      skid_d = skid_q;
    end
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = level_s[1:0];
    end
  end

  // Buffer and occupancy registers.
  always_ff @(posedge r_clk or negedge r_resetn) begin
    if (!r_resetn) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= {DATA_WD{1'b0}};
      skid_q     <= {DATA_WD{1'b0}};
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifdef RD_STREAM_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Statistics next state: delivered words wrap, stall cycles saturate.
  always_comb begin
    if (pop_s) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
    if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Statistics registers; only reset clears them.
  always_ff @(posedge r_clk or negedge r_resetn) begin
    if (!r_resetn) begin
      word_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue-based model of words read but not yet delivered.
module tb_fifo_rd_stream;

  logic       r_clk = 1'b0;
  logic       r_resetn;
  logic       empty_flag;
  logic [7:0] data_out;
  logic       r_enbl;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef RD_STREAM_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] m_word_cnt;
  logic [15:0] m_stall_cnt;
  int          pops_since_rst;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ent_t;

  ent_t       outq[$];
  logic [7:0] src[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         dut_reads;
  logic       rd_now;
  logic [7:0] rd_word;

  fifo_rd_stream #(.DATA_WD(8)) dut (
    .r_clk(r_clk), .r_resetn(r_resetn), .empty_flag(empty_flag), .data_out(data_out),
    .r_enbl(r_enbl), .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef RD_STREAM_STATS_EN
    , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic refill(input int n);
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  task automatic model_reset();
    outq.delete();
    rd_now = 1'b0;
`ifdef RD_STREAM_STATS_EN
    m_word_cnt     = 16'd0;
    m_stall_cnt    = 16'd0;
    pops_since_rst = 0;
`endif
  endtask

  // One read-clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic cycle(input logic rdy, input logic fl, input logic gap);
    logic exp_valid, exp_pop, exp_ren;
    m_ready    = rdy;
    flush      = fl;
    empty_flag = (src.size() == 0) || gap;
    @(negedge r_clk);
    exp_valid = (outq.size() > 0) && (outq[0].cyc + 2 <= cyc);
    check_eq("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
    if (exp_valid) check_eq("m_data", {24'd0, m_data}, {24'd0, outq[0].data});
    exp_pop = exp_valid & rdy;
    exp_ren = !empty_flag && !fl && ((outq.size() - int'(exp_pop)) < 2);
    check_eq("r_enbl", {31'd0, r_enbl}, {31'd0, exp_ren});
    if (r_enbl && !empty_flag) dut_reads++;
`ifdef RD_STREAM_STATS_EN
    check_eq("word_cnt", {16'd0, word_cnt}, {16'd0, m_word_cnt});
    check_eq("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall_cnt});
    if (exp_pop) begin
      m_word_cnt = m_word_cnt + 16'd1;
      pops_since_rst++;
    end
    if (exp_valid && !rdy && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
`endif
    if (exp_pop) void'(outq.pop_front());
    if (fl) outq.delete();
    rd_now = exp_ren;
    if (exp_ren) begin
      rd_word = src.pop_front();
      outq.push_back('{data: rd_word, cyc: cyc});
    end
    @(posedge r_clk);
    #1;
    data_out = rd_now ? rd_word : 8'($urandom);
  endtask

  initial begin
    r_resetn   = 1'b0;
    empty_flag = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b1;
    data_out   = 8'h00;
    model_reset();
    src.push_back(8'h11);
    src.push_back(8'h22);
    src.push_back(8'h33);
    @(posedge r_clk);
    #1;
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_m_data", {24'd0, m_data}, 32'd0);
    check_eq("rst_r_enbl", {31'd0, r_enbl}, 32'd0);
    @(posedge r_clk);
    #1;
    r_resetn = 1'b1;

    // Preloaded 0x11/0x22/0x33 drained with m_ready held high.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);

    // Back-pressure: exactly two reads while m_ready stays low.
    refill(6);
    dut_reads = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    check_eq("bp_reads", dut_reads, 32'd2);

    // Flush with a full buffer; the next delivery is the next unread FIFO word.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);

    // Alternating ready over a 16-word stream.
    refill(16);
    for (int i = 0; i < 40; i++) cycle(1'(i % 2 == 0), 1'b0, 1'b0);

    // Random ready, FIFO gaps and occasional flush (sometimes coinciding with a pop).
    for (int i = 0; i < 3000; i++) begin
      if (src.size() < 3 && $urandom_range(0, 2) == 0) refill(5);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 4) == 0));
    end

    // Asynchronous reset in the middle of a burst.
    refill(8);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    #2;
    r_resetn = 1'b0;
    #1;
    check_eq("arst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("arst_m_data", {24'd0, m_data}, 32'd0);
    check_eq("arst_r_enbl", {31'd0, r_enbl}, 32'd0);
`ifdef RD_STREAM_STATS_EN
    check_eq("arst_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
    @(posedge r_clk);
    #1;
    r_resetn = 1'b1;
    model_reset();
    src.delete();
    refill(6);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);

`ifdef RD_STREAM_STATS_EN
    // Word counter wrap after 65,537 pops since reset.
    #2;
    r_resetn = 1'b0;
    @(posedge r_clk);
    #1;
    r_resetn = 1'b1;
    model_reset();
    src.delete();
    while (pops_since_rst < 65537 && cyc < 90000) begin
      if (src.size() < 4) refill(8);
      cycle(1'b1, 1'b0, 1'b0);
    end
    check_eq("wrap_pops", pops_since_rst, 32'd65537);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("wrap_word_cnt", {16'd0, word_cnt}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
